// File: rtl/noc_local_ni.sv
// ---------------------------------------------------------------------------
// noc_local_ni
//
// Local network interface between a mesh node's host logic and the router's
// L port.
//   Transmit: packs host requests into 16-bit flits {payload, dest_x, dest_y}
//             and injects them with credit-based flow control.
//   Receive:  buffers flits ejected by the router in a first-word-fall-through
//             FIFO and returns one credit per flit the host consumes.
//
// Optional feature macro: NOC_NI_DEST_CHECK_EN
//   Defined   - flits whose destination is not (XCOORD, YCOORD) are discarded,
//               err_flags[2] is set and the credit is still returned.
//   Undefined - all flits are accepted; err_flags[2] is tied to 0.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   tx_valid/ready  host transmit handshake
//   tx_dest_x/y     destination coordinates of the host flit
//   tx_payload      payload byte of the host flit
//   link_o_data     registered flit to the router L input
//   link_o_enable   registered one-cycle flit strobe to the router
//   link_o_credit   credit pulse from the router (its L input FIFO popped)
//   link_i_data     flit from the router L output
//   link_i_enable   flit strobe from the router
//   link_i_credit   registered credit pulse back to the router
//   rx_valid/ready  host receive handshake (rx_valid = FIFO non-empty)
//   rx_data         head flit of the receive FIFO
//   tx_count        flits injected (wrapping)
//   rx_count        flits accepted into the receive FIFO (wrapping)
//   err_flags       sticky: [0] credit overflow, [1] rx FIFO overflow,
//                   [2] destination mismatch
// ---------------------------------------------------------------------------
module noc_local_ni #(
  parameter logic [3:0] XCOORD     = 4'd0,
  parameter logic [3:0] YCOORD     = 4'd0,
  parameter int         TX_CREDITS = 4,
  parameter int         RX_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tx_valid,
  output logic        tx_ready,
  input  logic [3:0]  tx_dest_x,
  input  logic [3:0]  tx_dest_y,
  input  logic [7:0]  tx_payload,
  output logic [15:0] link_o_data,
  output logic        link_o_enable,
  input  logic        link_o_credit,
  input  logic [15:0] link_i_data,
  input  logic        link_i_enable,
  output logic        link_i_credit,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic [15:0] rx_data,
  output logic [15:0] tx_count,
  output logic [15:0] rx_count,
  output logic [2:0]  err_flags
);

  localparam int CW = $clog2(TX_CREDITS + 1);
  localparam int OW = $clog2(RX_DEPTH + 1);
  localparam int PW = (RX_DEPTH > 1) ? $clog2(RX_DEPTH) : 1;

  localparam logic [CW-1:0] CREDIT_MAX = CW'(TX_CREDITS);
  localparam logic [OW-1:0] OCC_FULL   = OW'(RX_DEPTH);
  localparam logic [PW-1:0] PTR_LAST   = PW'(RX_DEPTH - 1);

  // State
  logic [CW-1:0] credit_q, credit_d;
  logic [15:0]   link_o_data_q, link_o_data_d;
  logic          link_o_enable_q, link_o_enable_d;
  logic          link_i_credit_q, link_i_credit_d;
  logic [15:0]   tx_count_q, tx_count_d;
  logic [15:0]   rx_count_q, rx_count_d;
  logic [2:0]    err_q, err_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [OW-1:0] occ_q, occ_d;
  logic [15:0]   mem_q [RX_DEPTH];

  // Per-cycle events
  logic tx_hs;
  logic rx_empty;
  logic rx_full;
  logic rx_pop;
  logic dest_ok;
  logic rx_push;
  logic rx_drop_full;
  logic rx_mismatch;

  assign tx_ready = (credit_q != '0);
  assign tx_hs    = tx_valid && tx_ready;

  assign rx_empty = (occ_q == '0);
  assign rx_full  = (occ_q == OCC_FULL);
  assign rx_pop   = !rx_empty && rx_ready;

`ifdef NOC_NI_DEST_CHECK_EN
  assign dest_ok = (link_i_data[7:0] == {XCOORD, YCOORD});
`else
  assign dest_ok = 1'b1;
`endif

  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign rx_push      = link_i_enable && dest_ok && (!rx_full || rx_pop);
  assign rx_drop_full = link_i_enable && dest_ok && rx_full && !rx_pop;
  assign rx_mismatch  = link_i_enable && !dest_ok;

`ifdef NOC_NI_DEST_CHECK_EN
  // A misrouted flit and a host pop in the same cycle each owe the router a
  // credit, but the link carries one pulse per cycle; the surplus is queued
  // here and drained on following cycles so the router's count stays exact.
  localparam int SW = OW + 1;
  logic [OW-1:0] credit_owed_q, credit_owed_d;
  logic [SW-1:0] credit_owed_sum;
  assign credit_owed_sum = {1'b0, credit_owed_q} + SW'(rx_pop) + SW'(rx_mismatch);
`endif

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
    return (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
  endfunction

  // NOTE: every variable assigned in this block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    credit_d        = credit_q;
    err_d           = err_q;
    link_o_enable_d = tx_hs;
    link_o_data_d   = link_o_data_q;
    tx_count_d      = tx_count_q;
    rx_count_d      = rx_count_q;
    rd_ptr_d        = rd_ptr_q;
    wr_ptr_d        = wr_ptr_q;
    occ_d           = occ_q;
    link_i_credit_d = rx_pop;

    // Transmit credits: a handshake and a returned credit cancel out.
    unique case ({tx_hs, link_o_credit})
      2'b10: credit_d = credit_q - 1'b1;
      2'b01: begin
        if (credit_q == CREDIT_MAX) err_d[0] = 1'b1;
        else                        credit_d = credit_q + 1'b1;
      end
      default: ;
    endcase

    if (tx_hs) begin
      link_o_data_d = {tx_payload, tx_dest_x, tx_dest_y};
      tx_count_d    = tx_count_q + 16'd1;
    end

    // Receive FIFO
    if (rx_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    if (rx_push) begin
      wr_ptr_d   = ptr_inc(wr_ptr_q);
      rx_count_d = rx_count_q + 16'd1;
    end
    occ_d = occ_q + OW'(rx_push) - OW'(rx_pop);
    if (rx_drop_full) err_d[1] = 1'b1;

`ifdef NOC_NI_DEST_CHECK_EN
    if (rx_mismatch) err_d[2] = 1'b1;
    credit_owed_d   = credit_owed_q;
    link_i_credit_d = 1'b0;
    if (credit_owed_sum != '0) begin
      link_i_credit_d = 1'b1;
      credit_owed_d   = OW'(credit_owed_sum - 1'b1);
    end
`else
    err_d[2] = 1'b0;
`endif
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the pre-edge value of every other flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      credit_q        <= CREDIT_MAX;
      link_o_data_q   <= '0;
      link_o_enable_q <= 1'b0;
      link_i_credit_q <= 1'b0;
      tx_count_q      <= '0;
      rx_count_q      <= '0;
      err_q           <= '0;
      rd_ptr_q        <= '0;
      wr_ptr_q        <= '0;
      occ_q           <= '0;
`ifdef NOC_NI_DEST_CHECK_EN
      credit_owed_q   <= '0;
`endif
    end else begin
      credit_q        <= credit_d;
      link_o_data_q   <= link_o_data_d;
      link_o_enable_q <= link_o_enable_d;
      link_i_credit_q <= link_i_credit_d;
      tx_count_q      <= tx_count_d;
      rx_count_q      <= rx_count_d;
      err_q           <= err_d;
      rd_ptr_q        <= rd_ptr_d;
      wr_ptr_q        <= wr_ptr_d;
      occ_q           <= occ_d;
`ifdef NOC_NI_DEST_CHECK_EN
      credit_owed_q   <= credit_owed_d;
`endif
    end
  end

  // NOTE: the storage array is deliberately not reset; the occupancy counter
  // and pointers define which entries are valid, so reset only clears those.
  always_ff @(posedge clk) begin
    if (rx_push) mem_q[wr_ptr_q] <= link_i_data;
  end

  assign link_o_data   = link_o_data_q;
  assign link_o_enable = link_o_enable_q;
  assign link_i_credit = link_i_credit_q;
  assign rx_valid      = !rx_empty;
  // Masked while empty so stale storage never shows on the port.
  assign rx_data       = rx_empty ? '0 : mem_q[rd_ptr_q];
  assign tx_count      = tx_count_q;
  assign rx_count      = rx_count_q;
  assign err_flags     = err_q;

endmodule

// File: tb/tb_noc_local_ni.sv
// ---------------------------------------------------------------------------
// tb_noc_local_ni
//
// Self-checking bench for noc_local_ni with default parameters (node (0,0),
// 4 transmit credits, 4-entry receive FIFO). Transmitted flits and received
// flits are tracked in scoreboard queues: expected values are pushed when the
// stimulus is driven and popped when the DUT presents the flit. Inputs change
// 1 time unit after the rising edge and outputs are sampled there too.
// ---------------------------------------------------------------------------
module tb_noc_local_ni;

  localparam int TXC = 4;
  localparam int RXD = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        tx_valid;
  logic        tx_ready;
  logic [3:0]  tx_dest_x;
  logic [3:0]  tx_dest_y;
  logic [7:0]  tx_payload;
  logic [15:0] link_o_data;
  logic        link_o_enable;
  logic        link_o_credit;
  logic [15:0] link_i_data;
  logic        link_i_enable;
  logic        link_i_credit;
  logic        rx_valid;
  logic        rx_ready;
  logic [15:0] rx_data;
  logic [15:0] tx_count;
  logic [15:0] rx_count;
  logic [2:0]  err_flags;

  noc_local_ni #(
    .XCOORD(4'd0), .YCOORD(4'd0), .TX_CREDITS(TXC), .RX_DEPTH(RXD)
  ) dut (
    .clk(clk), .rst(rst),
    .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_dest_x(tx_dest_x), .tx_dest_y(tx_dest_y), .tx_payload(tx_payload),
    .link_o_data(link_o_data), .link_o_enable(link_o_enable),
    .link_o_credit(link_o_credit),
    .link_i_data(link_i_data), .link_i_enable(link_i_enable),
    .link_i_credit(link_i_credit),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
    .tx_count(tx_count), .rx_count(rx_count), .err_flags(err_flags)
  );

  always #5 clk = ~clk;

  // Counters and reference model
  int          n_cmp = 0;
  int          n_bad = 0;
  int          m_credits;
  logic [15:0] m_tx_count;
  logic [15:0] m_rx_count;
  logic [2:0]  m_err;
  logic [15:0] tx_exp_q[$];
  logic [15:0] rx_exp_q[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tx_valid = 1'b0; tx_dest_x = '0; tx_dest_y = '0; tx_payload = '0;
    link_o_credit = 1'b0; link_i_data = '0; link_i_enable = 1'b0; rx_ready = 1'b0;
    step();
    rst = 1'b0;
    m_credits = TXC; m_tx_count = '0; m_rx_count = '0; m_err = '0;
    tx_exp_q.delete(); rx_exp_q.delete();
  endtask

  // One transmit-side cycle: drive, predict, clock, compare the scoreboard.
  task automatic tx_cycle(input logic v, input logic [3:0] dx, input logic [3:0] dy,
                          input logic [7:0] pl, input logic cr, output logic seen);
    logic        hs;
    logic [15:0] exp_flit;
    tx_valid = v; tx_dest_x = dx; tx_dest_y = dy; tx_payload = pl; link_o_credit = cr;
    hs = v && (m_credits != 0);
    n_cmp++;
    if (tx_ready !== (m_credits != 0)) begin
      n_bad++;
      $display("FAIL tx_ready: got %b want %b", tx_ready, (m_credits != 0));
    end
    if (hs) begin
      tx_exp_q.push_back({pl, dx, dy});
      m_tx_count++;
    end
    if (hs && !cr) m_credits--;
    else if (!hs && cr) begin
      if (m_credits == TXC) m_err[0] = 1'b1;
      else                  m_credits++;
    end
    step();
    tx_valid = 1'b0; link_o_credit = 1'b0;
    seen = link_o_enable;
    n_cmp++;
    if (link_o_enable !== hs) begin
      n_bad++;
      $display("FAIL link_o_enable: got %b want %b", link_o_enable, hs);
    end
    if (link_o_enable === 1'b1 && tx_exp_q.size() > 0) begin
      exp_flit = tx_exp_q.pop_front();
      n_cmp++;
      if (link_o_data !== exp_flit) begin
        n_bad++;
        $display("FAIL link_o_data: got %h want %h", link_o_data, exp_flit);
      end
    end
    n_cmp++;
    if (tx_count !== m_tx_count) begin
      n_bad++;
      $display("FAIL tx_count: got %0d want %0d", tx_count, m_tx_count);
    end
    n_cmp++;
    if (err_flags !== m_err) begin
      n_bad++;
      $display("FAIL err_flags(tx): got %b want %b", err_flags, m_err);
    end
  endtask

  // One receive-side cycle: drive, predict, clock, compare the scoreboard.
  task automatic rx_cycle(input logic en, input logic [15:0] d, input logic rdy);
    logic pop, dok, accept, mism, exp_cr;
    link_i_enable = en; link_i_data = d; rx_ready = rdy;
    n_cmp++;
    if (rx_valid !== (rx_exp_q.size() != 0)) begin
      n_bad++;
      $display("FAIL rx_valid: got %b want %b", rx_valid, (rx_exp_q.size() != 0));
    end
    if (rx_exp_q.size() != 0) begin
      n_cmp++;
      if (rx_data !== rx_exp_q[0]) begin
        n_bad++;
        $display("FAIL rx_data: got %h want %h", rx_data, rx_exp_q[0]);
      end
    end
    pop = rdy && (rx_exp_q.size() != 0);
`ifdef NOC_NI_DEST_CHECK_EN
    dok = (d[7:4] == 4'd0) && (d[3:0] == 4'd0);
`else
    dok = 1'b1;
`endif
    mism   = en && !dok;
    accept = en && dok && ((rx_exp_q.size() < RXD) || pop);
    if (mism) m_err[2] = 1'b1;
    if (en && dok && !accept) m_err[1] = 1'b1;
    if (pop) void'(rx_exp_q.pop_front());
    if (accept) begin
      rx_exp_q.push_back(d);
      m_rx_count++;
    end
    exp_cr = pop || mism;
    step();
    link_i_enable = 1'b0; rx_ready = 1'b0;
    n_cmp++;
    if (link_i_credit !== exp_cr) begin
      n_bad++;
      $display("FAIL link_i_credit: got %b want %b", link_i_credit, exp_cr);
    end
    n_cmp++;
    if (rx_count !== m_rx_count) begin
      n_bad++;
      $display("FAIL rx_count: got %0d want %0d", rx_count, m_rx_count);
    end
    n_cmp++;
    if (err_flags !== m_err) begin
      n_bad++;
      $display("FAIL err_flags(rx): got %b want %b", err_flags, m_err);
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (tx_ready !== 1'b1)       begin n_bad++; $display("FAIL reset tx_ready: got %b want 1", tx_ready); end
    n_cmp++; if (link_o_enable !== 1'b0)  begin n_bad++; $display("FAIL reset link_o_enable: got %b want 0", link_o_enable); end
    n_cmp++; if (link_o_data !== 16'h0)   begin n_bad++; $display("FAIL reset link_o_data: got %h want 0000", link_o_data); end
    n_cmp++; if (link_i_credit !== 1'b0)  begin n_bad++; $display("FAIL reset link_i_credit: got %b want 0", link_i_credit); end
    n_cmp++; if (rx_valid !== 1'b0)       begin n_bad++; $display("FAIL reset rx_valid: got %b want 0", rx_valid); end
    n_cmp++; if (rx_data !== 16'h0)       begin n_bad++; $display("FAIL reset rx_data: got %h want 0000", rx_data); end
    n_cmp++; if (tx_count !== 16'h0)      begin n_bad++; $display("FAIL reset tx_count: got %0d want 0", tx_count); end
    n_cmp++; if (rx_count !== 16'h0)      begin n_bad++; $display("FAIL reset rx_count: got %0d want 0", rx_count); end
    n_cmp++; if (err_flags !== 3'b000)    begin n_bad++; $display("FAIL reset err_flags: got %b want 000", err_flags); end
  endtask

  task automatic test_flit_packing();
    logic seen;
    tx_cycle(1'b1, 4'd3, 4'd2, 8'hA5, 1'b0, seen);
    n_cmp++; if (link_o_data !== 16'hA532) begin n_bad++; $display("FAIL pack data: got %h want a532", link_o_data); end
    n_cmp++; if (tx_count !== 16'd1)       begin n_bad++; $display("FAIL pack tx_count: got %0d want 1", tx_count); end
    tx_cycle(1'b0, 4'd9, 4'd9, 8'hFF, 1'b0, seen);
    n_cmp++; if (link_o_data !== 16'hA532) begin n_bad++; $display("FAIL pack hold: got %h want a532", link_o_data); end
    tx_cycle(1'b0, 4'd0, 4'd0, 8'h00, 1'b1, seen);
  endtask

  task automatic test_credit_exhaustion();
    logic seen;
    int   pulses = 0;
    for (int i = 0; i < 6; i++) begin
      tx_cycle(1'b1, 4'(i), 4'd1, 8'(8'h10 + i), 1'b0, seen);
      if (seen) pulses++;
    end
    n_cmp++; if (pulses != TXC)     begin n_bad++; $display("FAIL exhaust pulses: got %0d want %0d", pulses, TXC); end
    n_cmp++; if (tx_ready !== 1'b0) begin n_bad++; $display("FAIL exhaust tx_ready: got %b want 0", tx_ready); end
    tx_cycle(1'b0, 4'd0, 4'd0, 8'h00, 1'b1, seen);
    n_cmp++; if (tx_ready !== 1'b1) begin n_bad++; $display("FAIL credit return tx_ready: got %b want 1", tx_ready); end
    tx_cycle(1'b1, 4'd7, 4'd6, 8'h5A, 1'b0, seen);
    n_cmp++; if (seen !== 1'b1)     begin n_bad++; $display("FAIL fifth flit: got %b want 1", seen); end
    for (int i = 0; i < TXC; i++) tx_cycle(1'b0, 4'd0, 4'd0, 8'h00, 1'b1, seen);
    // One credit too many: saturates and flags overflow.
    tx_cycle(1'b0, 4'd0, 4'd0, 8'h00, 1'b1, seen);
    n_cmp++; if (err_flags[0] !== 1'b1) begin n_bad++; $display("FAIL credit overflow flag: got %b want 1", err_flags[0]); end
  endtask

  task automatic test_tx_simultaneous();
    logic seen;
    int   pulses = 0;
    tx_cycle(1'b1, 4'd1, 4'd1, 8'hC3, 1'b1, seen);
    for (int i = 0; i < 6; i++) begin
      tx_cycle(1'b1, 4'd2, 4'(i), 8'(8'h60 + i), 1'b0, seen);
      if (seen) pulses++;
    end
    n_cmp++; if (pulses != TXC) begin n_bad++; $display("FAIL simul tx pulses: got %0d want %0d", pulses, TXC); end
    for (int i = 0; i < TXC; i++) tx_cycle(1'b0, 4'd0, 4'd0, 8'h00, 1'b1, seen);
  endtask

  task automatic test_rx_simultaneous();
    for (int i = 0; i < RXD; i++) rx_cycle(1'b1, {4'(i + 1), 4'h1, 8'h00}, 1'b0);
    rx_cycle(1'b1, 16'h5500, 1'b1);
    n_cmp++; if (err_flags[1] !== 1'b0) begin n_bad++; $display("FAIL simul rx overflow: got %b want 0", err_flags[1]); end
    for (int i = 0; i < RXD; i++) rx_cycle(1'b0, 16'h0000, 1'b1);
    n_cmp++; if (rx_valid !== 1'b0) begin n_bad++; $display("FAIL simul rx drained: got %b want 0", rx_valid); end
  endtask

  task automatic test_rx_flow();
    do_reset();
    for (int i = 0; i < RXD; i++) rx_cycle(1'b1, {8'hA0 + 8'(i), 8'h00}, 1'b0);
    n_cmp++; if (rx_valid !== 1'b1) begin n_bad++; $display("FAIL rx_flow valid: got %b want 1", rx_valid); end
    rx_cycle(1'b1, 16'hEE00, 1'b0);
    n_cmp++; if (err_flags[1] !== 1'b1) begin n_bad++; $display("FAIL rx overflow flag: got %b want 1", err_flags[1]); end
    n_cmp++; if (rx_count !== 16'd4)    begin n_bad++; $display("FAIL rx_flow rx_count: got %0d want 4", rx_count); end
    for (int i = 0; i < RXD; i++) rx_cycle(1'b0, 16'h0000, 1'b1);
    rx_cycle(1'b0, 16'h0000, 1'b0);
  endtask

  task automatic test_dest_check();
    rx_cycle(1'b1, 16'h0011, 1'b0);
`ifdef NOC_NI_DEST_CHECK_EN
    n_cmp++; if (rx_valid !== 1'b0)     begin n_bad++; $display("FAIL dest stored: got %b want 0", rx_valid); end
    n_cmp++; if (err_flags[2] !== 1'b1) begin n_bad++; $display("FAIL dest flag: got %b want 1", err_flags[2]); end
`else
    n_cmp++; if (rx_valid !== 1'b1)     begin n_bad++; $display("FAIL dest accepted: got %b want 1", rx_valid); end
    n_cmp++; if (err_flags[2] !== 1'b0) begin n_bad++; $display("FAIL dest flag tied: got %b want 0", err_flags[2]); end
    rx_cycle(1'b0, 16'h0000, 1'b1);
`endif
    rx_cycle(1'b0, 16'h0000, 1'b0);
  endtask

  task automatic test_reset_mid();
    logic seen;
    int   pulses = 0;
    rx_cycle(1'b1, 16'hC100, 1'b0);
    rx_cycle(1'b1, 16'hC200, 1'b0);
    for (int i = 0; i < 3; i++) tx_cycle(1'b1, 4'd4, 4'(i), 8'h77, 1'b0, seen);
    // Reset lands on a cycle that would otherwise pop and transmit.
    rst = 1'b1; rx_ready = 1'b1; tx_valid = 1'b1;
    step();
    rst = 1'b0; rx_ready = 1'b0; tx_valid = 1'b0;
    n_cmp++; if (rx_valid !== 1'b0)      begin n_bad++; $display("FAIL mid reset rx_valid: got %b want 0", rx_valid); end
    n_cmp++; if (link_i_credit !== 1'b0) begin n_bad++; $display("FAIL mid reset link_i_credit: got %b want 0", link_i_credit); end
    n_cmp++; if (link_o_enable !== 1'b0) begin n_bad++; $display("FAIL mid reset link_o_enable: got %b want 0", link_o_enable); end
    n_cmp++; if (tx_ready !== 1'b1)      begin n_bad++; $display("FAIL mid reset tx_ready: got %b want 1", tx_ready); end
    n_cmp++; if (tx_count !== 16'd0)     begin n_bad++; $display("FAIL mid reset tx_count: got %0d want 0", tx_count); end
    n_cmp++; if (rx_count !== 16'd0)     begin n_bad++; $display("FAIL mid reset rx_count: got %0d want 0", rx_count); end
    n_cmp++; if (err_flags !== 3'b000)   begin n_bad++; $display("FAIL mid reset err_flags: got %b want 000", err_flags); end
    m_credits = TXC; m_tx_count = '0; m_rx_count = '0; m_err = '0;
    tx_exp_q.delete(); rx_exp_q.delete();
    for (int i = 0; i < 6; i++) begin
      tx_cycle(1'b1, 4'd5, 4'(i), 8'(8'h30 + i), 1'b0, seen);
      if (seen) pulses++;
    end
    n_cmp++; if (pulses != TXC) begin n_bad++; $display("FAIL mid reset credits: got %0d want %0d", pulses, TXC); end
  endtask

  initial begin
    test_reset();
    test_flit_packing();
    test_credit_exhaustion();
    test_tx_simultaneous();
    test_rx_simultaneous();
    test_rx_flow();
    test_dest_check();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
